// File: rtl/axi_dac_jesd204_tx_framer_if.sv
// DAC-side and link-side signal bundle for the JESD204 TX framer.
// The framer connects through the slave modport; the stimulus side uses master.
interface axi_dac_jesd204_tx_framer_if #(
  parameter int NUM_LANES    = 8,
  parameter int NUM_CHANNELS = 4
);
  logic                      tx_ready;
  logic [NUM_LANES*32-1:0]   tx_data;
  logic                      tx_valid;
  logic [NUM_LANES*32-1:0]   dac_data;
  logic                      dac_valid;
  logic                      dac_ready;
  logic [NUM_CHANNELS-1:0]   dac_enable;
  logic [1:0]                dac_mode;
  logic                      dac_underflow;
  logic                      dac_underflow_sticky;
  logic                      dac_underflow_clr;
  logic [1:0]                dac_state;

  modport master (
    output tx_ready,
    output dac_data,
    output dac_valid,
    output dac_enable,
    output dac_mode,
    output dac_underflow_clr,
    input  tx_data,
    input  tx_valid,
    input  dac_ready,
    input  dac_underflow,
    input  dac_underflow_sticky,
    input  dac_state
  );

  modport slave (
    input  tx_ready,
    input  dac_data,
    input  dac_valid,
    input  dac_enable,
    input  dac_mode,
    input  dac_underflow_clr,
    output tx_data,
    output tx_valid,
    output dac_ready,
    output dac_underflow,
    output dac_underflow_sticky,
    output dac_state
  );
endinterface

// File: rtl/axi_dac_jesd204_tx_framer.sv
// DAC-to-JESD204 TX framer: start-up sequencing, test patterns,
// channel masking, sample-to-octet mapping and output pipeline.
module axi_dac_jesd204_tx_framer #(
  parameter int NUM_LANES      = 8,
  parameter int NUM_CHANNELS   = 4,
  parameter int OCT_PER_SAMPLE = 2,
  parameter int START_DELAY    = 16,
  parameter int PIPE_STAGES    = 1
) (
  input logic tx_clk,
  input logic dac_rst,
  axi_dac_jesd204_tx_framer_if.slave bus
);

  localparam int W   = NUM_LANES * 32;
  localparam int S   = 8 * OCT_PER_SAMPLE;
  localparam int DPW = (4 * NUM_LANES) /
                       (OCT_PER_SAMPLE * NUM_CHANNELS);
  localparam int NS  = NUM_CHANNELS * DPW;
  localparam int CB  = DPW * S;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t         state_q;
  logic [7:0]     cnt_q;
  logic [S-1:0]   ramp_q [NUM_CHANNELS];
  logic [W-1:0]   pipe_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] pv_q;
  logic           sticky_q;

  logic           run;
  logic           mode_data;
  logic           mode_ramp;
  logic [W-1:0]   smp_d;
  logic [W-1:0]   oct_d;
  logic           uf_d;

  assign run       = (state_q == ST_RUN);
  assign mode_data = (bus.dac_mode == 2'd0);
  assign mode_ramp = (bus.dac_mode == 2'd2);

  // Link start-up sequencer; loss of tx_ready overrides every state
  always_ff @(posedge tx_clk) begin
    if (dac_rst) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
    end else if (!bus.tx_ready) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_WAIT: begin
          cnt_q   <= '0;
          state_q <= (START_DELAY == 0) ? ST_RUN : ST_FILL;
        end
        ST_FILL: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == 8'(START_DELAY - 1))
            state_q <= ST_RUN;
        end
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_WAIT;
      endcase
    end
  end

  // Ramp bases held at zero outside RUN so each RUN entry starts at 0
  always_ff @(posedge tx_clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (dac_rst || !run)
        ramp_q[i] <= '0;
      else
        ramp_q[i] <= ramp_q[i] + S'(DPW);
    end
  end

  // Beat source: mode select, then per-channel enable mask
  always_comb begin
    smp_d = '0;
    uf_d  = 1'b0;
    if (run) begin
      unique case (1'b1)
        mode_data: begin
          if (bus.dac_valid)
            smp_d = bus.dac_data;
          else
            uf_d = 1'b1;
        end
        mode_ramp: begin
          for (int i = 0; i < NUM_CHANNELS; i++)
            for (int j = 0; j < DPW; j++)
              smp_d[(i*DPW+j)*S +: S] = ramp_q[i] + S'(j);
        end
        default: smp_d = '0;
      endcase
      for (int i = 0; i < NUM_CHANNELS; i++)
        if (!bus.dac_enable[i])
          smp_d[i*CB +: CB] = '0;
    end
  end

  // Sample k, octet o (MSB first) lands on global octet k*OCT+o
  always_comb begin
    oct_d = '0;
    for (int k = 0; k < NS; k++)
      for (int o = 0; o < OCT_PER_SAMPLE; o++)
        oct_d[(k*OCT_PER_SAMPLE+o)*8 +: 8] =
          smp_d[k*S + (OCT_PER_SAMPLE-1-o)*8 +: 8];
  end

  // Output pipeline; reset flushes it without draining
  always_ff @(posedge tx_clk) begin
    if (dac_rst) begin
      for (int s = 0; s < PIPE_STAGES; s++)
        pipe_q[s] <= '0;
      pv_q <= '0;
    end else begin
      pipe_q[0] <= oct_d;
      pv_q[0]   <= run;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        pipe_q[s] <= pipe_q[s-1];
        pv_q[s]   <= pv_q[s-1];
      end
    end
  end

  // Sticky underflow; a new underflow beats a same-cycle clear
  always_ff @(posedge tx_clk) begin
    if (dac_rst)
      sticky_q <= 1'b0;
    else if (uf_d)
      sticky_q <= 1'b1;
    else if (bus.dac_underflow_clr)
      sticky_q <= 1'b0;
  end

  assign bus.tx_data              = pipe_q[PIPE_STAGES-1];
  assign bus.tx_valid             = pv_q[PIPE_STAGES-1];
  assign bus.dac_ready            = run;
  assign bus.dac_underflow        = uf_d;
  assign bus.dac_underflow_sticky = sticky_q;
  assign bus.dac_state            = state_q;

endmodule

// File: tb/tb_axi_dac_jesd204_tx_framer.sv
// Bench for the JESD204 TX framer: beat scoreboard plus
// per-feature tasks for start-up, mapping, underflow, ramp, masking, loss.
module tb_axi_dac_jesd204_tx_framer;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  typedef struct packed {
    logic [127:0] d;
    logic         v;
  } beat_t;

  beat_t sbq[$];

  axi_dac_jesd204_tx_framer_if #(
    .NUM_LANES(4), .NUM_CHANNELS(2)) bus ();
  axi_dac_jesd204_tx_framer_if #(
    .NUM_LANES(4), .NUM_CHANNELS(2)) bus2 ();

  axi_dac_jesd204_tx_framer #(
    .NUM_LANES(4), .NUM_CHANNELS(2),
    .OCT_PER_SAMPLE(2), .START_DELAY(3),
    .PIPE_STAGES(1)
  ) dut (
    .tx_clk(clk), .dac_rst(rst), .bus(bus)
  );

  axi_dac_jesd204_tx_framer #(
    .NUM_LANES(4), .NUM_CHANNELS(2),
    .OCT_PER_SAMPLE(1), .START_DELAY(2),
    .PIPE_STAGES(1)
  ) dut2 (
    .tx_clk(clk), .dac_rst(rst), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: expected beat per cycle, pushed at the sampling edge
  int          m_state;
  int          m_cnt;
  logic [15:0] m_ramp;

  always @(posedge clk) begin
    beat_t       b;
    logic [15:0] smp;
    int          k;
    int          ch;
    int          j;
    b = '0;
    if (rst) begin
      m_state = 0;
      m_cnt   = 0;
      m_ramp  = 16'd0;
    end else begin
      if (m_state == 2) begin
        b.v = 1'b1;
        for (int g = 0; g < 16; g++) begin
          k   = g / 2;
          ch  = k / 4;
          j   = k % 4;
          smp = 16'd0;
          if (bus.dac_enable[ch]) begin
            if (bus.dac_mode == 2'd0 && bus.dac_valid)
              smp = bus.dac_data[k*16 +: 16];
            else if (bus.dac_mode == 2'd2)
              smp = m_ramp + 16'(j);
          end
          b.d[g*8 +: 8] = (g % 2 == 0) ? smp[15:8] : smp[7:0];
        end
        m_ramp = m_ramp + 16'd4;
      end
      if (!bus.tx_ready) begin
        m_state = 0;
      end else if (m_state == 0) begin
        m_state = 1;
        m_cnt   = 0;
      end else if (m_state == 1) begin
        if (m_cnt == 2) begin
          m_state = 2;
          m_ramp  = 16'd0;
        end
        m_cnt = m_cnt + 1;
      end
    end
    sbq.push_back(b);
  end

  // Scoreboard compare, away from the active edge
  always @(negedge clk) begin
    beat_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_chk++;
      if (bus.tx_data !== e.d || bus.tx_valid !== e.v) begin
        n_fail++;
        $display("FAIL sb_beat t=%0t: got %h/%b want %h/%b",
                 $time, bus.tx_data, bus.tx_valid, e.d, e.v);
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic wait_run();
    int c;
    c = 0;
    while (bus.dac_state !== 2'd2 && c < 20) begin
      @(negedge clk);
      c++;
    end
    n_chk++;
    if (bus.dac_state !== 2'd2) begin
      n_fail++;
      $display("FAIL wait_run: state %0d want 2", bus.dac_state);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.tx_data !== 128'd0 || bus.tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tx: got %h/%b want 0/0",
               bus.tx_data, bus.tx_valid);
    end
    n_chk++;
    if (bus.dac_ready !== 1'b0 || bus.dac_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ctl: ready %b state %0d want 0/0",
               bus.dac_ready, bus.dac_state);
    end
    n_chk++;
    if (bus.dac_underflow !== 1'b0 ||
        bus.dac_underflow_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_uf: uf %b sticky %b want 0/0",
               bus.dac_underflow, bus.dac_underflow_sticky);
    end
    rst = 1'b0;
  endtask

  task automatic test_startup();
    logic [1:0] es;
    @(negedge clk);
    bus.dac_data  = rnd128();
    bus.dac_valid = 1'b1;
    bus.tx_ready  = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.dac_data = rnd128();
      es = (c < 4) ? 2'd1 : 2'd2;
      n_chk++;
      if (bus.dac_state !== es ||
          bus.dac_ready !== (c == 4)) begin
        n_fail++;
        $display("FAIL startup c%0d: state %0d ready %b want %0d/%b",
                 c, bus.dac_state, bus.dac_ready, es, c == 4);
      end
    end
  endtask

  task automatic test_mapping();
    logic [127:0] d;
    d = rnd128();
    d[15:0]    = 16'h1234;
    d[127:112] = 16'hBEEF;
    bus.dac_data = d;
    @(negedge clk);
    bus.dac_data = rnd128();
    n_chk++;
    if (bus.tx_data[7:0] !== 8'h12 ||
        bus.tx_data[15:8] !== 8'h34) begin
      n_fail++;
      $display("FAIL map_ch0s0: got %h want 3412",
               bus.tx_data[15:0]);
    end
    n_chk++;
    if (bus.tx_data[127:120] !== 8'hEF ||
        bus.tx_data[119:112] !== 8'hBE) begin
      n_fail++;
      $display("FAIL map_ch1s3: got %h want EFBE",
               bus.tx_data[127:112]);
    end
  endtask

  task automatic test_underflow();
    bus.dac_valid = 1'b0;
    #1;
    n_chk++;
    if (bus.dac_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_pulse: got %b want 1", bus.dac_underflow);
    end
    @(negedge clk);
    bus.dac_valid = 1'b1;
    #1;
    n_chk++;
    if (bus.dac_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_single: got %b want 0", bus.dac_underflow);
    end
    n_chk++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 128'd0 ||
        bus.dac_underflow_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_beat: %b %h sticky %b want 1/0/1",
               bus.tx_valid, bus.tx_data,
               bus.dac_underflow_sticky);
    end
    bus.dac_valid         = 1'b0;
    bus.dac_underflow_clr = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.dac_underflow_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_set_prio: sticky %b want 1",
               bus.dac_underflow_sticky);
    end
    bus.dac_valid = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.dac_underflow_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_clr: sticky %b want 0",
               bus.dac_underflow_sticky);
    end
    bus.dac_underflow_clr = 1'b0;
    bus.dac_mode  = 2'd1;
    bus.dac_valid = 1'b0;
    #1;
    n_chk++;
    if (bus.dac_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_mode1: got %b want 0", bus.dac_underflow);
    end
    @(negedge clk);
    bus.dac_mode  = 2'd0;
    bus.dac_valid = 1'b1;
    n_chk++;
    if (bus.dac_underflow_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_mode1_sticky: got %b want 0",
               bus.dac_underflow_sticky);
    end
  endtask

  task automatic test_enable_mode();
    logic [127:0] d;
    logic [127:0] ex;
    d  = rnd128();
    ex = '0;
    for (int k = 4; k < 8; k++) begin
      ex[(2*k)*8 +: 8]   = d[k*16+8 +: 8];
      ex[(2*k+1)*8 +: 8] = d[k*16 +: 8];
    end
    bus.dac_enable = 2'b10;
    bus.dac_data   = d;
    @(negedge clk);
    n_chk++;
    if (bus.tx_data !== ex) begin
      n_fail++;
      $display("FAIL enable_mask: got %h want %h", bus.tx_data, ex);
    end
    bus.dac_enable = 2'b11;
    bus.dac_mode   = 2'd3;
    bus.dac_data   = rnd128();
    @(negedge clk);
    n_chk++;
    if (bus.tx_data !== 128'd0 || bus.tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mode3_zero: got %h/%b want 0/1",
               bus.tx_data, bus.tx_valid);
    end
    bus.dac_mode = 2'd0;
  endtask

  task automatic test_link_loss();
    bus.dac_data = rnd128();
    bus.tx_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.dac_state !== 2'd0 || bus.dac_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_state: %0d/%b want 0/0",
               bus.dac_state, bus.dac_ready);
    end
    @(negedge clk);
    n_chk++;
    if (bus.tx_data !== 128'd0 || bus.tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_data: %h/%b want 0/0",
               bus.tx_data, bus.tx_valid);
    end
  endtask

  task automatic test_ramp();
    logic [63:0] ex;
    bus.dac_mode = 2'd2;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    wait_run();
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++)
        ex[j*16 +: 16] = {8'(4*b + j), 8'h00};
      n_chk++;
      if (bus.tx_data[63:0] !== ex) begin
        n_fail++;
        $display("FAIL ramp_b%0d: got %h want %h",
                 b, bus.tx_data[63:0], ex);
      end
    end
    bus.dac_mode = 2'd0;
  endtask

  task automatic test_reset_mid_run();
    bus.dac_valid = 1'b0;
    @(negedge clk);
    bus.dac_valid = 1'b1;
    n_chk++;
    if (bus.dac_underflow_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_sticky: got %b want 1",
               bus.dac_underflow_sticky);
    end
    bus.dac_data = rnd128();
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.tx_data !== 128'd0 || bus.tx_valid !== 1'b0 ||
        bus.dac_ready !== 1'b0 || bus.dac_state !== 2'd0 ||
        bus.dac_underflow_sticky !== 1'b0 ||
        bus.dac_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_run: %h %b %b %0d %b %b want all 0",
               bus.tx_data, bus.tx_valid, bus.dac_ready,
               bus.dac_state, bus.dac_underflow_sticky,
               bus.dac_underflow);
    end
    rst = 1'b0;
  endtask

  task automatic test_ramp_wrap();
    logic [127:0] ex;
    int c;
    bus2.dac_mode  = 2'd2;
    bus2.dac_valid = 1'b1;
    bus2.tx_ready  = 1'b1;
    c = 0;
    @(negedge clk);
    while (bus2.dac_state !== 2'd2 && c < 20) begin
      @(negedge clk);
      c++;
    end
    n_chk++;
    if (bus2.dac_state !== 2'd2) begin
      n_fail++;
      $display("FAIL wrap_run: state %0d want 2", bus2.dac_state);
    end
    for (int b = 0; b < 34; b++) begin
      @(negedge clk);
      for (int k = 0; k < 16; k++)
        ex[k*8 +: 8] = 8'(8*b + (k % 8));
      n_chk++;
      if (bus2.tx_data !== ex || bus2.tx_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_b%0d: got %h/%b want %h/1",
                 b, bus2.tx_data, bus2.tx_valid, ex);
      end
      if (b == 31) begin
        n_chk++;
        if (bus2.tx_data[63:56] !== 8'hFF) begin
          n_fail++;
          $display("FAIL wrap_ff: got %h want ff",
                   bus2.tx_data[63:56]);
        end
      end
      if (b == 32) begin
        n_chk++;
        if (bus2.tx_data[7:0] !== 8'h00) begin
          n_fail++;
          $display("FAIL wrap_00: got %h want 00",
                   bus2.tx_data[7:0]);
        end
      end
    end
    bus2.tx_ready = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.tx_ready          = 1'b0;
    bus.dac_data          = '0;
    bus.dac_valid         = 1'b0;
    bus.dac_enable        = 2'b11;
    bus.dac_mode          = 2'd0;
    bus.dac_underflow_clr = 1'b0;
    bus2.tx_ready          = 1'b0;
    bus2.dac_data          = '0;
    bus2.dac_valid         = 1'b0;
    bus2.dac_enable        = 2'b11;
    bus2.dac_mode          = 2'd0;
    bus2.dac_underflow_clr = 1'b0;
    test_reset();
    test_startup();
    test_mapping();
    test_underflow();
    test_enable_mode();
    test_link_loss();
    test_ramp();
    test_reset_mid_run();
    test_ramp_wrap();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
